// File: rtl/l2sw_pkg.sv
// l2sw_pkg: shared constants and types for the L2 switch RX path.
//   N_PORT        number of RX PHY ports
//   IDX_W         width of a port index
//   sched_state_e RX scheduler FSM states
package l2sw_pkg;
    localparam int N_PORT = 4;
    localparam int IDX_W  = 2;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} sched_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req   in   per-port request vector
//   last  in   most recently served port; search starts at last+1
//   pick  out  first requesting port at or after last+1, wrapping
//   any   out  at least one request is present
module rr_pick
    import l2sw_pkg::*;
(
    input  logic [N_PORT-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic [IDX_W-1:0]  pick,
    output logic              any
);
    logic [IDX_W-1:0] idx;

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = N_PORT; i >= 1; i--) begin
            idx = IDX_W'((int'(last) + i) % N_PORT);
            if (req[idx]) pick = idx;
        end
    end

    assign any = |req;
endmodule

// File: rtl/rx_frame_scheduler.sv
// rx_frame_scheduler: round-robin arbiter giving the MAC decoder one RX FIFO
// per frame, with a read-inactivity watchdog and per-port frame counters.
//   clk          in   switch clock
//   arst_n       in   asynchronous active-low reset
//   frame_exist  in   complete frame present in RX FIFO i
//   port_mask    in   1 = port i excluded from arbitration
//   dec_ready    in   decoder can accept a new frame
//   dec_rden     in   decoder read strobe (activity only)
//   dec_eod      in   decoder reached end of frame
//   grant        out  granted port index, holds when not valid
//   grant_valid  out  decoder owns port grant
//   dec_start    out  one-cycle pulse at grant start
//   abort        out  one-cycle pulse on watchdog timeout
//   grant_cnt    out  completed-frame counters, port i at [i*CNT_W +: CNT_W]
module rx_frame_scheduler
    import l2sw_pkg::*;
#(
    parameter int TIMEOUT = 2048,
    parameter int HOLDOFF = 3,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic [N_PORT-1:0]       frame_exist,
    input  logic [N_PORT-1:0]       port_mask,
    input  logic                    dec_ready,
    input  logic                    dec_rden,
    input  logic                    dec_eod,
    output logic [IDX_W-1:0]        grant,
    output logic                    grant_valid,
    output logic                    dec_start,
    output logic                    abort,
    output logic [N_PORT*CNT_W-1:0] grant_cnt
);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam int HO_W = $clog2(HOLDOFF + 1);

    sched_state_e      state_q;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  last_q;
    logic              valid_q;
    logic              start_q;
    logic              abort_q;
    logic [WD_W-1:0]   wd_q;
    logic [HO_W-1:0]   ho_q;
    logic [CNT_W-1:0]  cnt_q [N_PORT];
    logic [N_PORT-1:0] req_d;
    logic [IDX_W-1:0]  pick_d;
    logic              any_d;

    assign req_d = frame_exist & ~port_mask;

    rr_pick u_pick (
        .req  (req_d),
        .last (last_q),
        .pick (pick_d),
        .any  (any_d)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(N_PORT - 1);
            valid_q <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            wd_q    <= '0;
            ho_q    <= '0;
            for (int i = 0; i < N_PORT; i++) cnt_q[i] <= '0;
        end else begin
            start_q <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dec_ready && any_d) begin
                        state_q <= BUSY;
                        grant_q <= pick_d;
                        valid_q <= 1'b1;
                        start_q <= 1'b1;
                        wd_q    <= '0;
                    end
                end
                BUSY: begin
                    // End of frame has priority over the watchdog, and a read
                    // strobe in the timeout cycle still counts as activity.
                    if (dec_eod) begin
                        state_q        <= DONE;
                        valid_q        <= 1'b0;
                        last_q         <= grant_q;
                        ho_q           <= '0;
                        cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
                    end else if (dec_rden) begin
                        wd_q <= '0;
                    end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        last_q  <= grant_q;
                        ho_q    <= '0;
                        abort_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                DONE: begin
                    // Holdoff lets frame_exist of the served port settle
                    // across its CDC before it can be re-arbitrated.
                    if (ho_q == HO_W'(HOLDOFF - 1)) state_q <= IDLE;
                    else ho_q <= ho_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign dec_start   = start_q;
    assign abort       = abort_q;

    for (genvar g = 0; g < N_PORT; g++) begin : g_cnt
        assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
endmodule

// File: tb/tb_rx_frame_scheduler.sv
// tb_rx_frame_scheduler: self-checking bench for rx_frame_scheduler.
// Narrow counters keep the wrap-around test short.
module tb_rx_frame_scheduler;
    localparam int TIMEOUT = 2048;
    localparam int HOLDOFF = 3;
    localparam int CW      = 8;

    logic          clk;
    logic          arst_n;
    logic [3:0]    frame_exist;
    logic [3:0]    port_mask;
    logic          dec_ready;
    logic          dec_rden;
    logic          dec_eod;
    logic [1:0]    grant;
    logic          grant_valid;
    logic          dec_start;
    logic          abort;
    logic [4*CW-1:0] grant_cnt;

    int checks = 0;
    int errors = 0;
    int abort_cnt = 0;
    logic [1:0]    sb [$];
    logic [CW-1:0] exp_cnt [4];

    typedef struct {
        logic [3:0] fe;
        logic [3:0] mask;
        logic [1:0] g;
        bit         hold;
    } vec_t;
    vec_t vecs [14];

    rx_frame_scheduler #(
        .TIMEOUT (TIMEOUT),
        .HOLDOFF (HOLDOFF),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .frame_exist (frame_exist),
        .port_mask   (port_mask),
        .dec_ready   (dec_ready),
        .dec_rden    (dec_rden),
        .dec_eod     (dec_eod),
        .grant       (grant),
        .grant_valid (grant_valid),
        .dec_start   (dec_start),
        .abort       (abort),
        .grant_cnt   (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (abort) abort_cnt <= abort_cnt + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, required finish before 1ms");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic chk_cnt();
        for (int p = 0; p < 4; p++)
            chk($sformatf("grant_cnt%0d", p), 32'(grant_cnt[p*CW +: CW]), 32'(exp_cnt[p]));
    endtask

    // Waits for the next dec_start, pops the scoreboard and checks latency.
    task automatic wait_grant(input int lat, input bit hold);
        int n = 0;
        logic [1:0] e;
        do begin
            @(posedge clk); #1;
            n++;
            if (hold) chk("mask_hold", 32'(grant), 0);
        end while (!dec_start && n < 50);
        chk("dec_start", 32'(dec_start), 1);
        e = (sb.size() != 0) ? sb.pop_front() : 2'd0;
        chk("sb_grant", 32'(grant), 32'(e));
        chk("grant_valid_on", 32'(grant_valid), 1);
        if (lat != 0) chk("grant_latency", n, lat);
    endtask

    task automatic run_frame(input logic [3:0] fe, input logic [3:0] m, input logic [1:0] g,
                             input int lat, input bit hold);
        frame_exist = fe;
        port_mask   = m;
        dec_ready   = 1'b1;
        sb.push_back(g);
        wait_grant(lat, hold);
        dec_ready = 1'b0;
        @(posedge clk); #1;
        chk("dec_start_pulse", 32'(dec_start), 0);
        dec_rden = 1'b1;
        @(posedge clk); #1;
        dec_rden = 1'b0;
        dec_eod  = 1'b1;
        @(posedge clk); #1;
        dec_eod = 1'b0;
        exp_cnt[g] = exp_cnt[g] + 1'b1;
        chk("grant_valid_off", 32'(grant_valid), 0);
        if (hold) chk("mask_hold", 32'(grant), 0);
        chk_cnt();
    endtask

    initial begin
        int a0, n;
        vecs[0]  = '{4'b0101, 4'b0000, 2'd0, 1'b0};
        vecs[1]  = '{4'b0101, 4'b0000, 2'd2, 1'b0};
        vecs[2]  = '{4'b0101, 4'b0000, 2'd0, 1'b0};
        vecs[3]  = '{4'b1111, 4'b0000, 2'd1, 1'b0};
        vecs[4]  = '{4'b1111, 4'b0000, 2'd2, 1'b0};
        vecs[5]  = '{4'b1111, 4'b0000, 2'd3, 1'b0};
        vecs[6]  = '{4'b1111, 4'b0000, 2'd0, 1'b0};
        vecs[7]  = '{4'b1111, 4'b0000, 2'd1, 1'b0};
        vecs[8]  = '{4'b1111, 4'b0000, 2'd2, 1'b0};
        vecs[9]  = '{4'b1111, 4'b0000, 2'd3, 1'b0};
        vecs[10] = '{4'b1111, 4'b0000, 2'd0, 1'b0};
        vecs[11] = '{4'b0011, 4'b0010, 2'd0, 1'b1};
        vecs[12] = '{4'b0011, 4'b0010, 2'd0, 1'b1};
        vecs[13] = '{4'b0011, 4'b0010, 2'd0, 1'b1};
        for (int p = 0; p < 4; p++) exp_cnt[p] = '0;

        arst_n = 1'b0; frame_exist = '0; port_mask = '0;
        dec_ready = 1'b0; dec_rden = 1'b0; dec_eod = 1'b0;
        #3;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_valid", 32'(grant_valid), 0);
        chk("rst_start", 32'(dec_start), 0);
        chk("rst_abort", 32'(abort), 0);
        chk("rst_cnt", 32'(grant_cnt), 0);
        #4 arst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            run_frame(vecs[i].fe, vecs[i].mask, vecs[i].g, (i == 0) ? 1 : HOLDOFF + 1, vecs[i].hold);

        // Watchdog abort on port 3; the next search must start after port 3.
        frame_exist = 4'b1000; port_mask = '0; dec_ready = 1'b1;
        sb.push_back(2'd3);
        wait_grant(HOLDOFF + 1, 1'b0);
        dec_ready = 1'b0; frame_exist = 4'b0011;
        a0 = abort_cnt; n = 0;
        do begin @(posedge clk); #1; n++; end while (!abort && n < TIMEOUT + 10);
        chk("abort_pulse", 32'(abort), 1);
        chk("abort_latency", n, TIMEOUT);
        chk("abort_valid", 32'(grant_valid), 0);
        @(posedge clk); #1;
        chk("abort_single", 32'(abort), 0);
        chk("abort_count", abort_cnt - a0, 1);
        chk_cnt();
        dec_ready = 1'b1;
        sb.push_back(2'd0);
        wait_grant(HOLDOFF, 1'b0);
        dec_ready = 1'b0;

        // dec_eod in the timeout cycle wins over the abort.
        a0 = abort_cnt;
        repeat (TIMEOUT - 1) @(posedge clk);
        #1 dec_eod = 1'b1;
        @(posedge clk); #1;
        dec_eod = 1'b0;
        exp_cnt[0] = exp_cnt[0] + 1'b1;
        chk("eod_to_abort", 32'(abort), 0);
        chk("eod_to_valid", 32'(grant_valid), 0);
        @(posedge clk); #1;
        chk("eod_to_count", abort_cnt - a0, 0);
        chk_cnt();

        // dec_rden in the timeout cycle clears the watchdog.
        dec_ready = 1'b1;
        sb.push_back(2'd1);
        wait_grant(HOLDOFF, 1'b0);
        dec_ready = 1'b0;
        a0 = abort_cnt;
        repeat (TIMEOUT - 1) @(posedge clk);
        #1 dec_rden = 1'b1;
        @(posedge clk); #1;
        dec_rden = 1'b0;
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        chk("rden_to_valid", 32'(grant_valid), 1);
        chk("rden_to_count", abort_cnt - a0, 0);
        dec_eod = 1'b1;
        @(posedge clk); #1;
        dec_eod = 1'b0;
        exp_cnt[1] = exp_cnt[1] + 1'b1;
        chk("rden_to_end", 32'(grant_valid), 0);
        chk_cnt();

        // Drive port 1 counter to all-ones, then wrap it.
        while (exp_cnt[1] != {CW{1'b1}}) run_frame(4'b0010, 4'b0000, 2'd1, HOLDOFF + 1, 1'b0);
        run_frame(4'b0010, 4'b0000, 2'd1, HOLDOFF + 1, 1'b0);
        chk("cnt1_wrap", 32'(grant_cnt[CW +: CW]), 0);

        // Asynchronous reset in the middle of a frame.
        frame_exist = 4'b0100; dec_ready = 1'b1;
        sb.push_back(2'd2);
        wait_grant(HOLDOFF + 1, 1'b0);
        dec_ready = 1'b0;
        @(posedge clk);
        #3 arst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 0);
        chk("arst_valid", 32'(grant_valid), 0);
        chk("arst_start", 32'(dec_start), 0);
        chk("arst_abort", 32'(abort), 0);
        chk("arst_cnt", 32'(grant_cnt), 0);
        for (int p = 0; p < 4; p++) exp_cnt[p] = '0;
        #2 arst_n = 1'b1;
        run_frame(4'b1111, 4'b0000, 2'd0, 1, 1'b0);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rx_frame_scheduler.md
# rx_frame_scheduler

Round-robin scheduler that shares the single MAC decoder among the four per-PHY RX frame FIFOs. It sits between the RX FRAME_FIFO status flags and MAC_DEC on the 100 MHz switch clock. It grants one port at a time for a whole frame, holds the grant until end-of-frame or a read-inactivity timeout, and keeps per-port grant counters for SoC monitoring.

## Interface
- N_PORT, 4: number of RX ports; grant index width is fixed at 2 bits.
- TIMEOUT, 2048: idle cycles without a read strobe in BUSY before the frame is aborted.
- HOLDOFF, 3: cycles spent in DONE, which covers the frame_exist CDC settling delay.
- CNT_W, 16: width of each per-port grant counter.

Ports:
- clk  in  1  switch clock.
- arst_n  in  1  reset, asynchronous, active-low.
- frame_exist  in  N_PORT  complete frame present in RX FIFO i.
- port_mask  in  N_PORT  1 = port i is excluded from arbitration.
- dec_ready  in  1  decoder idle and header/body FIFOs have room.
- dec_rden  in  1  decoder read strobe to the granted FIFO; used only as activity.
- dec_eod  in  1  decoder saw end-of-frame (del) on the granted FIFO.
- grant  out  2  index of the granted port; holds its last value when not valid.
- grant_valid  out  1  grant is active and the decoder owns port `grant`.
- dec_start  out  1  one-cycle pulse at the start of each grant.
- abort  out  1  one-cycle pulse when a frame times out.
- grant_cnt  out  N_PORT*CNT_W  completed-frame counters; port i occupies bits [i*CNT_W +: CNT_W].

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - Eligible requests are req = frame_exist & ~port_mask.
  - When dec_ready=1 and req≠0, pick the first set bit of req, searching upward from last+1 and wrapping modulo N_PORT.
  - Go to BUSY and register grant = pick.
- BUSY:
  - grant_valid=1.
  - Watchdog counter clears on dec_rden and otherwise increments.
  - On dec_eod, go to DONE and increment grant_cnt[grant].
  - When the watchdog reaches TIMEOUT-1 without dec_eod, pulse abort, go to DONE, and leave the counter unchanged.
- DONE:
  - grant_valid=0 and last=grant.
  - A holdoff counter runs HOLDOFF cycles, then the block returns to IDLE.
- Ignored inputs:
  - dec_eod outside BUSY.
  - Changes to frame_exist or port_mask during BUSY; the grant is never revoked by them.
- Arithmetic:
  - grant_cnt wraps from 2^CNT_W-1 to 0.
  - The watchdog counter is clog2(TIMEOUT) bits wide and saturates by leaving BUSY.

## Timing
- All outputs are registered.
- Reset values:
  - Outputs: grant=0, grant_valid=0, dec_start=0, abort=0, grant_cnt=0.
  - Internal: state=IDLE, last=N_PORT-1, so port 0 wins the first arbitration.
- Grant latency:
  - req and dec_ready are sampled at edge N.
  - grant, grant_valid=1 and dec_start=1 are visible after edge N; dec_start falls after edge N+1.
- End of frame:
  - dec_eod sampled at edge M.
  - grant_valid=0 and the counter update are visible after edge M.
  - The next grant's grant_valid can be visible no earlier than after edge M+HOLDOFF+1.
- dec_eod and the timeout in the same cycle: dec_eod wins, with no abort and the counter incremented.
- dec_rden and the timeout in the same cycle: dec_rden wins and the watchdog clears.
- Asserting arst_n low mid-frame immediately forces all outputs to their reset values. The decoder must treat the falling grant_valid as an abandon.

## Structure
- Shared package `l2sw_pkg`: N_PORT, the state enum (IDLE/BUSY/DONE), and the port index width.
- Sub-module `rr_pick`: combinational round-robin priority encoder with inputs req and last, and outputs pick and any.
- The top holds the FSM, watchdog, holdoff and counters.

## Test plan
- Reset, then frame_exist=4'b0101 and dec_ready=1:
  - grant=0 with a dec_start pulse.
  - After dec_eod, wait HOLDOFF cycles; next grant=2, then grant=0.
  - grant_cnt port 0 = 2, port 2 = 1.
- All four ports requesting continuously, 8 frames: grant sequence 0,1,2,3,0,1,2,3, and each counter = 2.
- port_mask=4'b0010 with frame_exist=4'b0011: port 1 is never granted; grant stays 0 on every cycle.
- Grant port 3, then no dec_rden for TIMEOUT cycles: one abort pulse, grant_valid drops, grant_cnt port 3 unchanged, and the next arbitration starts after port 3.
- dec_eod and the timeout in the same cycle: no abort, and the counter increments.
- With grant_cnt port 1 preloaded to 0xFFFF by running frames, one more frame leaves it at 0x0000.
- Assert arst_n mid-BUSY: all outputs 0 asynchronously. After release, the first grant goes to port 0.
